cache_l2_nway_control: RTL

CACHE_L2_NWAY_CONTROL -- requirements
Module: cache_l2_nway_control

---
 rtl/cache_l2_nway_control.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/cache_l2_nway_control.sv
// Control FSM for an N-way L2 cache: demand hit/miss handling with write-back
// of dirty victims, write-allocate fills, next-line prefetch and saturating
// hit/miss/prefetch statistics.
//
//   state      | meaning
//   CHECK      | tag lookup; serve demand hits, launch misses or a pending prefetch
//   WRITE_BACK | dirty victim being written to memory
//   FETCH      | line being read from memory into the PMDR
//   FILL       | PMDR written into the victim way (one cycle)
module cache_l2_nway_control #(
  parameter int WAYS        = 4,
  parameter int PREFETCH_EN = 1,
  parameter int CNT_W       = 16,
  localparam int WW         = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic             mem_resp,
  input  logic             hit,
  input  logic [WW-1:0]    hit_way,
  input  logic [WW-1:0]    victim_way,
  input  logic             victim_dirty,
  input  logic             pmem_resp,
  output logic             pmem_read,
  output logic             pmem_write,
  output logic [WW-1:0]    way_sel,
  output logic             array_load,
  output logic             lru_load,
  output logic             dirty_load,
  output logic             dirty_val,
  output logic             pmdr_load,
  output logic             datawritemux_sel,
  output logic             pmemaddrmux_sel,
  output logic             addrmux_sel,
  output logic             prefetch,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [CNT_W-1:0] pf_cnt
);

  typedef enum logic [1:0] {CHECK, WRITE_BACK, FETCH, FILL} state_e;

  localparam logic PF_ON = (PREFETCH_EN != 0);

  state_e           state_q, state_d;
  logic             pf_pending_q, pf_pending_d;
  logic [WW-1:0]    victim_q, victim_d;
  // Set while the in-flight miss belongs to a prefetch; also the held addrmux_sel.
  logic             op_pf_q, op_pf_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
  logic [CNT_W-1:0] pf_cnt_q, pf_cnt_d;

  logic demand;
  logic pf_req;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign demand = mem_read | mem_write;
  // A demand request always wins over a pending prefetch.
  assign pf_req = PF_ON & pf_pending_q & ~demand;

  // State and bookkeeping registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= CHECK;
      pf_pending_q <= 1'b0;
      victim_q     <= '0;
      op_pf_q      <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      pf_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      pf_pending_q <= pf_pending_d;
      victim_q     <= victim_d;
      op_pf_q      <= op_pf_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      pf_cnt_q     <= pf_cnt_d;
    end
  end

  // Next-state, victim/operation latching, prefetch flag and statistics.
  always_comb begin
    state_d      = state_q;
    pf_pending_d = pf_pending_q;
    victim_d     = victim_q;
    op_pf_d      = op_pf_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    pf_cnt_d     = pf_cnt_q;
    case (state_q)
      CHECK: begin
        if (demand) begin
          if (hit) begin
            hit_cnt_d = sat_inc(hit_cnt_q);
          end else begin
            victim_d   = victim_way;
            op_pf_d    = 1'b0;
            miss_cnt_d = sat_inc(miss_cnt_q);
            state_d    = victim_dirty ? WRITE_BACK : FETCH;
          end
        end else if (pf_req) begin
          if (hit) begin
            pf_pending_d = 1'b0;
          end else begin
            victim_d = victim_way;
            op_pf_d  = 1'b1;
            pf_cnt_d = sat_inc(pf_cnt_q);
            state_d  = victim_dirty ? WRITE_BACK : FETCH;
          end
        end
      end
      WRITE_BACK: if (pmem_resp) state_d = FETCH;
      FETCH:      if (pmem_resp) state_d = FILL;
      FILL: begin
        // A demand fill arms the next-line prefetch; a prefetch fill retires it.
        pf_pending_d = op_pf_q ? 1'b0 : PF_ON;
        state_d      = CHECK;
      end
      default: state_d = CHECK;
    endcase
  end

  // Output decode; everything is held low while reset is asserted.
  always_comb begin
    mem_resp         = 1'b0;
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;
    way_sel          = '0;
    array_load       = 1'b0;
    lru_load         = 1'b0;
    dirty_load       = 1'b0;
    dirty_val        = 1'b0;
    pmdr_load        = 1'b0;
    datawritemux_sel = 1'b0;
    pmemaddrmux_sel  = 1'b0;
    addrmux_sel      = op_pf_q;
    prefetch         = op_pf_q;
    case (state_q)
      CHECK: begin
        addrmux_sel = pf_req;
        prefetch    = pf_req;
        if (demand && hit) begin
          mem_resp = 1'b1;
          lru_load = 1'b1;
          way_sel  = hit_way;
          if (mem_write) begin
            array_load       = 1'b1;
            dirty_load       = 1'b1;
            dirty_val        = 1'b1;
            datawritemux_sel = 1'b1;
          end
        end
      end
      WRITE_BACK: begin
        way_sel         = victim_q;
        pmem_write      = 1'b1;
        pmemaddrmux_sel = 1'b1;
      end
      FETCH: begin
        way_sel   = victim_q;
        pmem_read = 1'b1;
        pmdr_load = 1'b1;
      end
      FILL: begin
        way_sel    = victim_q;
        array_load = 1'b1;
        dirty_load = 1'b1;
        lru_load   = ~op_pf_q;
      end
      default: ;
    endcase
    if (!rst_n) begin
      mem_resp         = 1'b0;
      pmem_read        = 1'b0;
      pmem_write       = 1'b0;
      way_sel          = '0;
      array_load       = 1'b0;
      lru_load         = 1'b0;
      dirty_load       = 1'b0;
      dirty_val        = 1'b0;
      pmdr_load        = 1'b0;
      datawritemux_sel = 1'b0;
      pmemaddrmux_sel  = 1'b0;
      addrmux_sel      = 1'b0;
      prefetch         = 1'b0;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
  assign pf_cnt   = pf_cnt_q;

endmodule
